any1_pit_ctrl: RTL

Bus-master sequencer that shares the three-channel programmable interval timer between NREQ software or hardware requesters. It arbitrates round-robin among requests and executes each granted request as a fixed sequence of bus cycles: either a configure (max count, on time, control with load) or a current-count read. Only the granted counter's byte lane of the control register is written, so channels owned by different requesters never disturb each other. Sits between requesters and the timer's slave port on the I/O bus.

---
 rtl/any1_pit_pkg.sv | 43 ++++
 rtl/any1_pit_if.sv | 24 ++
 rtl/any1_rr_arb.sv | 43 ++++
 rtl/any1_pit_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/any1_pit_pkg.sv
// any1_pit_pkg: shared definitions for the PIT bus-master sequencer.
// Register map, control-bit layout, FSM states and mode bundle.
package any1_pit_pkg;

    localparam logic [3:0] PIT_CNT = 4'd0;
    localparam logic [3:0] PIT_MAX = 4'd4;
    localparam logic [3:0] PIT_ONT = 4'd8;
    localparam logic [3:0] PIT_CTL = 4'd12;

    localparam int LD = 0;
    localparam int CE = 1;
    localparam int AR = 2;
    localparam int XC = 3;
    localparam int GE = 4;

    typedef enum logic [2:0] {
        IDLE,
        WMAX,
        WONT,
        WCTL,
        RCNT,
        FIN
    } pit_state_t;

    typedef struct packed {
        logic ge;
        logic xc;
        logic ar;
        logic ce;
    } pit_mode_t;

    function automatic logic [7:0] ctl_byte(pit_mode_t m);
        logic [7:0] b;
        b = '0;
        b[LD] = 1'b1;
        b[CE] = m.ce;
        b[AR] = m.ar;
        b[XC] = m.xc;
        b[GE] = m.ge;
        return b;
    endfunction

endpackage

// File: rtl/any1_pit_if.sv
// any1_pit_if: I/O bus between the sequencer (master) and the timer slave.
// Directions in the signal names are seen from the master side.
interface any1_pit_if;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [5:0]  adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output dat_i, ack_i
    );

endinterface

// File: rtl/any1_rr_arb.sv
// any1_rr_arb: round-robin arbiter; the pointer moves past the winner
// only on cycles where en is high and a grant is issued.
module any1_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [IW-1:0] ptr;

    always_comb begin
        int j;
        j       = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!gnt_vld && req[j]) begin
                gnt_vld   = 1'b1;
                gnt_oh[j] = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (en && gnt_vld) begin
            ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/any1_pit_ctrl.sv
// any1_pit_ctrl: shares the 3-channel PIT among NREQ requesters.
// Configure: done_o 5 edges after grant; read: 1 + slave read wait edges.
module any1_pit_ctrl
    import any1_pit_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TMO  = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   op_i,
    input  logic [2*NREQ-1:0] ctr_i,
    input  logic [32*NREQ-1:0] max_i,
    input  logic [32*NREQ-1:0] ont_i,
    input  logic [4*NREQ-1:0] mode_i,
    output logic [NREQ-1:0]   done_o,
    output logic              err_o,
    output logic [31:0]       rdat_o,
    output logic              busy_o,
    any1_pit_if.master        bus
);

    localparam int IW = $clog2(NREQ);

    pit_state_t    state;
    logic [IW-1:0] win;
    logic [NREQ-1:0] win_oh;
    logic [1:0]    r_ctr;
    logic [31:0]   r_max;
    logic [31:0]   r_ont;
    pit_mode_t     r_mode;
    logic [7:0]    tmo;

    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;

    logic          w_op;
    logic [1:0]    w_ctr;
    logic [31:0]   w_max;
    logic [31:0]   w_ont;
    pit_mode_t     w_mode;

    logic [1:0]    c_ctr;
    logic [31:0]   c_max;
    logic [31:0]   c_ont;
    pit_mode_t     c_mode;
    pit_state_t    tgt;
    pit_state_t    nxt;
    logic          launch;
    logic          l_we;
    logic [3:0]    l_sel;
    logic [5:0]    l_adr;
    logic [31:0]   l_dat;

    any1_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en      (state == IDLE),
        .req     (req_i),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;

    always_comb begin
        w_op   = 1'b0;
        w_ctr  = '0;
        w_max  = '0;
        w_ont  = '0;
        w_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                w_op   = op_i[i];
                w_ctr  = ctr_i[2*i +: 2];
                w_max  = max_i[32*i +: 32];
                w_ont  = ont_i[32*i +: 32];
                w_mode = pit_mode_t'(mode_i[4*i +: 4]);
            end
        end
    end

    // In IDLE the first access launches straight from the winner's inputs.
    always_comb begin
        c_ctr  = r_ctr;
        c_max  = r_max;
        c_ont  = r_ont;
        c_mode = r_mode;
        tgt    = state;
        if (state == IDLE) begin
            c_ctr  = w_ctr;
            c_max  = w_max;
            c_ont  = w_ont;
            c_mode = w_mode;
            tgt    = w_op ? RCNT : WMAX;
        end
        l_we  = 1'b1;
        l_sel = 4'hF;
        l_dat = '0;
        l_adr = {c_ctr, PIT_CNT};
        unique case (tgt)
            WMAX: begin
                l_adr = {c_ctr, PIT_MAX};
                l_dat = c_max;
            end
            WONT: begin
                l_adr = {c_ctr, PIT_ONT};
                l_dat = c_ont;
            end
            WCTL: begin
                l_adr = {c_ctr, PIT_CTL};
                l_dat = {4{ctl_byte(c_mode)}};
                l_sel = 4'b0001 << c_ctr;
            end
            RCNT: l_we = 1'b0;
            default: l_we = 1'b1;
        endcase
    end

    always_comb begin
        nxt = FIN;
        unique case (state)
            WMAX:    nxt = WONT;
            WONT:    nxt = WCTL;
            default: nxt = FIN;
        endcase
        launch = (state == IDLE && gnt_vld && w_ctr != 2'd3) ||
                 (state inside {WMAX, WONT, WCTL, RCNT} && !bus.cyc_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            win       <= '0;
            r_ctr     <= '0;
            r_max     <= '0;
            r_ont     <= '0;
            r_mode    <= '0;
            tmo       <= '0;
            done_o    <= '0;
            err_o     <= 1'b0;
            rdat_o    <= '0;
            busy_o    <= 1'b0;
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
            bus.we_o  <= 1'b0;
            bus.sel_o <= '0;
            bus.adr_o <= '0;
            bus.dat_o <= '0;
        end else begin
            done_o <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        win    <= gnt_idx;
                        r_ctr  <= w_ctr;
                        r_max  <= w_max;
                        r_ont  <= w_ont;
                        r_mode <= w_mode;
                        if (w_ctr == 2'd3) begin
                            state  <= FIN;
                            done_o <= gnt_oh;
                            err_o  <= 1'b1;
                        end else begin
                            state  <= tgt;
                            busy_o <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    err_o <= 1'b0;
                end
                default: begin
                    if (bus.cyc_o) begin
                        if (bus.ack_i) begin
                            bus.cyc_o <= 1'b0;
                            bus.stb_o <= 1'b0;
                            if (state == RCNT) rdat_o <= bus.dat_i;
                            state <= nxt;
                            if (nxt == FIN) begin
                                done_o <= win_oh;
                                busy_o <= 1'b0;
                            end
                        end else if (tmo == 8'(TMO - 1)) begin
                            bus.cyc_o <= 1'b0;
                            bus.stb_o <= 1'b0;
                            state     <= FIN;
                            done_o    <= win_oh;
                            err_o     <= 1'b1;
                            busy_o    <= 1'b0;
                        end else begin
                            tmo <= tmo + 8'd1;
                        end
                    end
                end
            endcase
            if (launch) begin
                bus.cyc_o <= 1'b1;
                bus.stb_o <= 1'b1;
                bus.we_o  <= l_we;
                bus.sel_o <= l_sel;
                bus.adr_o <= l_adr;
                bus.dat_o <= l_dat;
                tmo       <= '0;
            end
        end
    end

endmodule
